// File: rtl/ascon_perm_counter.sv
// Bit counter and round sequencer for the serial Ascon permutation FSM.
// Provides phase-end detection, round tracking and the round constant.
module ascon_perm_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       perm_start,
    input  logic [3:0] rounds_cfg,
    input  logic       start_count,
    input  logic [5:0] value,
    input  logic       start_iteration,
    output logic       count_done,
    output logic [3:0] iteration,
    output logic       iteration_done,
    output logic [7:0] rc_byte,
    output logic       rc_bit
);

    logic [5:0] r_cnt;
    logic [3:0] r_idx;
    logic [3:0] r_rnd;

    logic       w_at_end;
    logic [3:0] w_rnd_cfg;
    logic [3:0] w_base;
    logic [3:0] w_iter;
    logic       w_done;
    logic [2:0] w_bit_sel;

    // Lowering value below cnt mid-phase ends the phase at once.
    assign w_at_end = (r_cnt >= value);
    assign count_done = start_count & w_at_end;

    // Out-of-range round counts fall back to the full 12 rounds.
    assign w_rnd_cfg = ((rounds_cfg == 4'd0) || (rounds_cfg > 4'd12))
                     ? 4'd12 : rounds_cfg;

    // Short permutations start partway into the constant table.
    assign w_base = 4'd12 - r_rnd;
    assign w_iter = r_idx - w_base;
    assign w_done = (w_iter == r_rnd);

    assign iteration      = w_iter;
    assign iteration_done = w_done;

    // Constant pairs a descending high nibble with the round index.
    assign rc_byte = (r_idx < 4'd12) ? {4'hF - r_idx, r_idx} : 8'h00;

    // Serial constant goes out MSB first over the first eight counts.
    assign w_bit_sel = 3'd7 - r_cnt[2:0];
    assign rc_bit    = (r_cnt < 6'd8) ? rc_byte[w_bit_sel] : 1'b0;

    // Bit counter: runs while a phase is active, wraps on terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 6'd0;
        end else if (!start_count || w_at_end) begin
            r_cnt <= 6'd0;
        end else begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    // Round latch and index: perm_start wins over a same-cycle step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rnd <= 4'd12;
            r_idx <= 4'd0;
        end else if (perm_start) begin
            r_rnd <= w_rnd_cfg;
            r_idx <= 4'd12 - w_rnd_cfg;
        end else if (start_iteration && !w_done) begin
            r_idx <= r_idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_ascon_perm_counter.sv
// Scoreboard bench for ascon_perm_counter: stimulus queues expected
// outputs, a negedge monitor pops and compares them.
module tb_ascon_perm_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       perm_start;
    logic [3:0] rounds_cfg;
    logic       start_count;
    logic [5:0] value;
    logic       start_iteration;
    logic       count_done;
    logic [3:0] iteration;
    logic       iteration_done;
    logic [7:0] rc_byte;
    logic       rc_bit;

    localparam int F_CD   = 0;
    localparam int F_IT   = 1;
    localparam int F_DONE = 2;
    localparam int F_RC   = 3;
    localparam int F_BIT  = 4;

    typedef struct {
        string      name;
        int         fld;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    logic       e1_bits [8] = '{1'b1, 1'b1, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b1};
    int         phase_v [3] = '{55, 7, 63};

    ascon_perm_counter dut (
        .clk            (clk),
        .rst            (rst),
        .perm_start     (perm_start),
        .rounds_cfg     (rounds_cfg),
        .start_count    (start_count),
        .value          (value),
        .start_iteration(start_iteration),
        .count_done     (count_done),
        .iteration      (iteration),
        .iteration_done (iteration_done),
        .rc_byte        (rc_byte),
        .rc_bit         (rc_bit)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] observe(int f);
        case (f)
            F_CD:    observe = {7'd0, count_done};
            F_IT:    observe = {4'd0, iteration};
            F_DONE:  observe = {7'd0, iteration_done};
            F_RC:    observe = rc_byte;
            default: observe = {7'd0, rc_bit};
        endcase
    endfunction

    // Monitor: drains every expectation queued during this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [7:0] got;
            e   = sb.pop_front();
            got = observe(e.fld);
            n_total++;
            if (got !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got=%h want=%h", e.name, got, e.exp);
            end
        end
    end

    task automatic expect_out(string n, int f, logic [7:0] v);
        exp_t e;
        e.name = n;
        e.fld  = f;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_iter();
        start_iteration = 1'b1;
        step();
        start_iteration = 1'b0;
    endtask

    task automatic start_perm(logic [3:0] cfg);
        perm_start = 1'b1;
        rounds_cfg = cfg;
        step();
        perm_start = 1'b0;
    endtask

    task automatic expect_idle_reset(string n);
        expect_out({n, "_cd"},   F_CD,   8'h00);
        expect_out({n, "_it"},   F_IT,   8'h00);
        expect_out({n, "_done"}, F_DONE, 8'h00);
        expect_out({n, "_rc"},   F_RC,   8'hF0);
        expect_out({n, "_bit"},  F_BIT,  8'h01);
    endtask

    initial begin
        rst             = 1'b0;
        perm_start      = 1'b0;
        rounds_cfg      = 4'd0;
        start_count     = 1'b0;
        value           = 6'd0;
        start_iteration = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        expect_idle_reset("reset");

        // Reset mid-phase with cnt=30 and idx=1.
        pulse_iter();
        expect_out("pre_rst_rc", F_RC, 8'hE1);
        start_count = 1'b1;
        value       = 6'd63;
        for (int k = 0; k < 30; k++) step();
        expect_out("cnt30_bit", F_BIT, 8'h00);
        expect_out("cnt30_cd",  F_CD,  8'h00);
        step();
        rst = 1'b0;
        expect_idle_reset("midrst");
        step();
        rst = 1'b1;
        start_count = 1'b0;
        expect_idle_reset("post_rst");
        step();

        // Back-to-back phases of 56, 8 and 64 cycles.
        start_count = 1'b1;
        for (int p = 0; p < 3; p++) begin
            value = phase_v[p][5:0];
            for (int k = 1; k <= phase_v[p] + 1; k++) begin
                expect_out($sformatf("phase%0d_k%0d", phase_v[p], k), F_CD,
                           (k == phase_v[p] + 1) ? 8'h01 : 8'h00);
                step();
            end
        end
        start_count = 1'b0;

        // Twelve rounds, then an extra pulse.
        start_perm(4'd12);
        for (int i = 0; i < 12; i++) begin
            expect_out($sformatf("r12_rc%0d", i),   F_RC,   rc_tab[i]);
            expect_out($sformatf("r12_it%0d", i),   F_IT,   8'(i));
            expect_out($sformatf("r12_done%0d", i), F_DONE, 8'h00);
            pulse_iter();
        end
        expect_out("r12_it_end",   F_IT,   8'd12);
        expect_out("r12_done_end", F_DONE, 8'h01);
        expect_out("r12_rc_end",   F_RC,   8'h00);
        pulse_iter();
        expect_out("r12_sat_it",   F_IT,   8'd12);
        expect_out("r12_sat_done", F_DONE, 8'h01);

        // Six rounds start at 96 and end after 4B.
        start_perm(4'd6);
        for (int i = 0; i < 6; i++) begin
            expect_out($sformatf("r6_rc%0d", i),   F_RC,   rc_tab[6 + i]);
            expect_out($sformatf("r6_it%0d", i),   F_IT,   8'(i));
            expect_out($sformatf("r6_done%0d", i), F_DONE, 8'h00);
            pulse_iter();
        end
        expect_out("r6_it_end",   F_IT,   8'd6);
        expect_out("r6_done_end", F_DONE, 8'h01);
        step();
        expect_out("r6_done_hold", F_DONE, 8'h01);

        // Round counts 0 and 15 clamp to 12.
        start_perm(4'd0);
        expect_out("cfg0_rc",   F_RC,   8'hF0);
        expect_out("cfg0_done", F_DONE, 8'h00);
        start_perm(4'd15);
        expect_out("cfg15_rc",   F_RC,   8'hF0);
        expect_out("cfg15_done", F_DONE, 8'h00);
        for (int i = 0; i < 11; i++) pulse_iter();
        expect_out("cfg15_it11",   F_IT,   8'd11);
        expect_out("cfg15_done11", F_DONE, 8'h00);
        expect_out("cfg15_rc11",   F_RC,   8'h4B);
        pulse_iter();
        expect_out("cfg15_done12", F_DONE, 8'h01);

        // Serial constant for idx=1, then zero past cnt=7.
        start_perm(4'd12);
        pulse_iter();
        start_count = 1'b1;
        value       = 6'd7;
        for (int k = 0; k < 8; k++) begin
            expect_out($sformatf("rcbit%0d", k), F_BIT, {7'd0, e1_bits[k]});
            step();
        end
        value = 6'd20;
        for (int k = 0; k < 8; k++) step();
        for (int k = 8; k < 12; k++) begin
            expect_out($sformatf("rcbit_hi%0d", k), F_BIT, 8'h00);
            step();
        end
        start_count = 1'b0;
        step();

        // perm_start wins over a same-cycle start_iteration.
        perm_start      = 1'b1;
        start_iteration = 1'b1;
        rounds_cfg      = 4'd12;
        step();
        perm_start      = 1'b0;
        start_iteration = 1'b0;
        expect_out("coll_it", F_IT, 8'h00);
        expect_out("coll_rc", F_RC, 8'hF0);

        // Terminal count dropped below cnt ends the phase that cycle.
        start_count = 1'b1;
        value       = 6'd63;
        for (int k = 0; k < 19; k++) step();
        expect_out("drop_cnt19", F_CD, 8'h00);
        step();
        value = 6'd10;
        expect_out("drop_cnt20", F_CD, 8'h01);
        step();
        expect_out("drop_wrap", F_CD, 8'h00);
        step();
        start_count = 1'b0;
        step();

        n_total++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
